// File: rtl/keypad_encoder.sv
// keypad_encoder -- microwave-style time entry from a 10-key digit pad.
//
// Raw key lines are synchronized, optionally debounced, and each accepted
// single-key press shifts a BCD digit into a 3-digit register
// (mins : sec_tens sec_ones). The oldest digit falls off the top; no range
// normalization is applied.
//
// Configuration macro: KEYPAD_DEBOUNCE_EN
//   defined   -> a key must be seen stable for DEBOUNCE_CYCLES synchronized
//                samples before it is evaluated (latency N+2+DEBOUNCE_CYCLES).
//   undefined -> the first nonzero synchronized sample is evaluated directly
//                (latency N+3); DEBOUNCE_CYCLES has no effect.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   keypad[9:0]  in   raw key lines, bit k = digit k pressed (asynchronous)
//   enable       in   entry permitted when high
//   clear        in   synchronous clear of entered time (wins over everything)
//   sec_ones     out  seconds units digit (BCD)
//   sec_tens     out  seconds tens digit (BCD)
//   mins         out  minutes digit (BCD)
//   digit_valid  out  one-cycle pulse, digit accepted
//   key_err      out  one-cycle pulse, more than one key seen
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] keypad,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       digit_valid,
  output logic       key_err
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

`ifdef KEYPAD_DEBOUNCE_EN
  // With a one-sample requirement the first sample is already stable enough.
  localparam logic       DIRECT_EVAL = (DEBOUNCE_CYCLES <= 1);
  // Counter value held on the edge that completes the stable run.
  localparam logic [7:0] DB_LAST     = 8'(DEBOUNCE_CYCLES - 1);
`else
  // Debounce disabled: every first sample is evaluated directly.
  localparam logic       DIRECT_EVAL = (DEBOUNCE_CYCLES > 0) || 1'b1;
`endif

  // True when exactly one key line is set.
  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  // Index of the highest set key line (only used on one-hot values).
  function automatic logic [3:0] key_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) idx = 4'(k);
      else      idx = idx;
    end
    return idx;
  endfunction

  logic [9:0] sync1_r, sync2_r;
  state_t     state_r, state_s;
  logic [9:0] cap_r, cap_s;
  logic [7:0] cnt_r, cnt_s;
  logic [3:0] ones_r, ones_s, tens_r, tens_s, mins_r, mins_s;
  logic       dv_r, dv_s, ke_r, ke_s;
  logic       eval_s;
  logic [9:0] eval_val_s;

  // Next-state, digit shift and pulse generation.
  always_comb begin
    state_s    = state_r;
    cap_s      = cap_r;
    cnt_s      = cnt_r;
    ones_s     = ones_r;
    tens_s     = tens_r;
    mins_s     = mins_r;
    dv_s       = 1'b0;
    ke_s       = 1'b0;
    eval_s     = 1'b0;
    eval_val_s = cap_r;

    case (state_r)
      IDLE: begin
        if (sync2_r != 10'd0) begin
          cap_s      = sync2_r;
          cnt_s      = 8'd1;
          eval_val_s = sync2_r;
          if (DIRECT_EVAL) eval_s  = 1'b1;
          else             state_s = DEBOUNCE;
        end else begin
          cnt_s = 8'd0;
        end
      end
      DEBOUNCE: begin
`ifdef KEYPAD_DEBOUNCE_EN
        if (sync2_r == 10'd0) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else if (sync2_r == cap_r) begin
          if (cnt_r >= DB_LAST) eval_s = 1'b1;
          else                  cnt_s  = cnt_r + 8'd1;
        end else begin
          // A different key pattern restarts the stability run.
          cap_s = sync2_r;
          cnt_s = 8'd1;
        end
`else
        state_s = IDLE;
        cnt_s   = 8'd0;
`endif
      end
      WAIT_RELEASE: begin
        if (sync2_r == 10'd0) state_s = IDLE;
        else                  state_s = WAIT_RELEASE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase

    // Evaluate a stable pattern: one key shifts in, several keys flag an error.
    if (eval_s) begin
      state_s = WAIT_RELEASE;
      cnt_s   = 8'd0;
      if (is_onehot(eval_val_s)) begin
        mins_s = tens_r;
        tens_s = ones_r;
        ones_s = key_index(eval_val_s);
        dv_s   = 1'b1;
      end else begin
        ke_s   = 1'b1;
      end
    end else begin
      cnt_s = cnt_s;
    end

    // clear beats enable-low, which beats normal operation. Parking in
    // WAIT_RELEASE ensures a key held across either event is never accepted.
    case ({clear, enable})
      2'b01: begin
      end
      2'b00: begin
        state_s = WAIT_RELEASE;
        cnt_s   = 8'd0;
        ones_s  = ones_r;
        tens_s  = tens_r;
        mins_s  = mins_r;
        dv_s    = 1'b0;
        ke_s    = 1'b0;
      end
      default: begin
        state_s = WAIT_RELEASE;
        cnt_s   = 8'd0;
        ones_s  = 4'd0;
        tens_s  = 4'd0;
        mins_s  = 4'd0;
        dv_s    = 1'b0;
        ke_s    = 1'b0;
      end
    endcase
  end

  // Synchronizer, FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 10'd0;
      sync2_r <= 10'd0;
      state_r <= IDLE;
      cap_r   <= 10'd0;
      cnt_r   <= 8'd0;
      ones_r  <= 4'd0;
      tens_r  <= 4'd0;
      mins_r  <= 4'd0;
      dv_r    <= 1'b0;
      ke_r    <= 1'b0;
    end else begin
      sync1_r <= keypad;
      sync2_r <= sync1_r;
      state_r <= state_s;
      cap_r   <= cap_s;
      cnt_r   <= cnt_s;
      ones_r  <= ones_s;
      tens_r  <= tens_s;
      mins_r  <= mins_s;
      dv_r    <= dv_s;
      ke_r    <= ke_s;
    end
  end

  assign sec_ones    = ones_r;
  assign sec_tens    = tens_r;
  assign mins        = mins_r;
  assign digit_valid = dv_r;
  assign key_err     = ke_r;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a table of key presses with expected
// pulse counts and digits, plus hand-written bounce / clear / enable / reset
// sequences. Expected latencies follow the build configuration.
module tb_keypad_encoder;

  localparam int DB = 4;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int LAT = DB + 2;
  localparam int DEB = 1;
`else
  localparam int LAT = 3;
  localparam int DEB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] keypad;
  logic       enable;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       digit_valid, key_err;

  keypad_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .keypad(keypad), .enable(enable), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .digit_valid(digit_valid), .key_err(key_err)
  );

  always #5 clk = ~clk;

  int   applied = 0;
  int   miscompares = 0;
  int   dv_cnt, ke_cnt, first_dv, last_dv;
  logic prev_pulse = 1'b0;

  typedef struct {
    logic [9:0] k;
    bit         clr;
    int         dv;
    int         ke;
    int         m;
    int         t;
    int         o;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_digits(input string name, input int m, input int t, input int o);
    check({name, ".mins"}, mins, m);
    check({name, ".sec_tens"}, sec_tens, t);
    check({name, ".sec_ones"}, sec_ones, o);
  endtask

  // Applies key k for 'hold' cycles (odd cycles below 'bounce' are released),
  // clear during cycle clr_at, enable low during cycles en_lo..en_hi.
  // Cycle 0 starts just after a rising edge; pulses are sampled on falling edges.
  task automatic run(input logic [9:0] k, input int hold, input int total,
                     input int clr_at, input int en_lo, input int en_hi, input int bounce);
    dv_cnt = 0; ke_cnt = 0; first_dv = -1; last_dv = -1;
    keypad = (hold > 0) ? k : 10'd0;
    clear  = (clr_at == 0);
    enable = !(0 >= en_lo && 0 <= en_hi);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (digit_valid) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = i;
        last_dv = i;
      end
      if (key_err) ke_cnt++;
      if ((digit_valid && key_err) || (prev_pulse && (digit_valid || key_err))) begin
        miscompares++;
        $display("FAIL pulse_rule: cycle %0d dv=%0b ke=%0b prev=%0b, required exclusive one-cycle pulses",
                 i, digit_valid, key_err, prev_pulse);
      end
      prev_pulse = digit_valid | key_err;
      @(posedge clk);
      #1;
      keypad = ((i + 1) < hold && !((i + 1) < bounce && ((i + 1) % 2) == 1)) ? k : 10'd0;
      clear  = ((i + 1) == clr_at);
      enable = !((i + 1) >= en_lo && (i + 1) <= en_hi);
    end
  endtask

  task automatic do_clear(input string name);
    run(10'd0, 0, 3, 0, -1, -2, 0);
    check_digits(name, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_at;
    vecs[0]  = '{10'b0000000010, 1'b1, 1, 0, 0, 0, 1};
    vecs[1]  = '{10'b0000001000, 1'b0, 1, 0, 0, 1, 3};
    vecs[2]  = '{10'b0000000001, 1'b0, 1, 0, 1, 3, 0};
    vecs[3]  = '{10'b0000000010, 1'b1, 1, 0, 0, 0, 1};
    vecs[4]  = '{10'b0000000100, 1'b0, 1, 0, 0, 1, 2};
    vecs[5]  = '{10'b0000001000, 1'b0, 1, 0, 1, 2, 3};
    vecs[6]  = '{10'b0000010000, 1'b0, 1, 0, 2, 3, 4};
    vecs[7]  = '{10'b0010000100, 1'b0, 0, 1, 2, 3, 4};
    vecs[8]  = '{10'b1000000000, 1'b0, 1, 0, 3, 4, 9};
    vecs[9]  = '{10'b0010000000, 1'b0, 1, 0, 4, 9, 7};
    vecs[10] = '{10'b1111111111, 1'b0, 0, 1, 4, 9, 7};
    vecs[11] = '{10'b0100000000, 1'b0, 1, 0, 9, 7, 8};

    // Reset state
    rst_n = 1'b0; keypad = 10'd0; enable = 1'b1; clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.dv", digit_valid, 0);
    check("reset.ke", key_err, 0);
    check_digits("reset", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(10'd0, 0, 4, -1, -1, -2, 0);

    // Table of single presses
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr) do_clear($sformatf("v%0d.clear", v));
      run(vecs[v].k, 10, 20, -1, -1, -2, 0);
      check($sformatf("v%0d.dv_count", v), dv_cnt, vecs[v].dv);
      check($sformatf("v%0d.ke_count", v), ke_cnt, vecs[v].ke);
      if (vecs[v].dv == 1) check($sformatf("v%0d.latency", v), first_dv, LAT);
      check_digits($sformatf("v%0d", v), vecs[v].m, vecs[v].t, vecs[v].o);
    end

    // Bouncing key 5: k,0,k,0 then stable from cycle 4
    do_clear("bounce.clear");
    run(10'b0000100000, 28, 38, -1, -1, -2, 4);
    check("bounce.dv_count", dv_cnt, (DEB == 1) ? 1 : 3);
    check("bounce.last_dv", last_dv, 4 + LAT);
    check("bounce.sec_ones", sec_ones, 5);

    // 1:30 entered, clear while 9 is held, then 9 pressed again
    do_clear("hold.clear");
    run(10'b0000000010, 10, 20, -1, -1, -2, 0);
    run(10'b0000001000, 10, 20, -1, -1, -2, 0);
    run(10'b0000000001, 10, 20, -1, -1, -2, 0);
    check_digits("hold.entered", 1, 3, 0);
    run(10'b1000000000, 15, 25, 1, -1, -2, 0);
    check("hold.dv_count", dv_cnt, 0);
    check_digits("hold.cleared", 0, 0, 0);
    run(10'b1000000000, 10, 20, -1, -1, -2, 0);
    check("repress.dv_count", dv_cnt, 1);
    check_digits("repress", 0, 0, 9);

    // clear on the very edge that would accept key 2
    run(10'b0000000100, 10, 20, LAT - 1, -1, -2, 0);
    check("clr_prio.dv_count", dv_cnt, 0);
    check_digits("clr_prio", 0, 0, 0);

    // enable low while key 4 pressed, raised while still held
    run(10'b0001000000, 10, 20, -1, -1, -2, 0);
    run(10'b0000010000, 15, 25, -1, 0, 7, 0);
    check("enable.dv_count", dv_cnt, 0);
    check("enable.ke_count", ke_cnt, 0);
    check_digits("enable", 0, 0, 6);

    // clear together with enable low still zeroes the digits
    run(10'd0, 0, 3, 0, 0, 0, 0);
    check_digits("clr_en_low", 0, 0, 0);

    // Reset in the middle of debouncing key 8
    run(10'b0000001000, 10, 20, -1, -1, -2, 0);
    check("pre_reset.sec_ones", sec_ones, 3);
    rst_at = (DEB == 1) ? 5 : 2;
    keypad = 10'b0100000000;
    dv_cnt = 0;
    for (int i = 0; i < rst_at; i++) begin
      @(negedge clk);
      if (digit_valid) dv_cnt++;
      @(posedge clk); #1;
    end
    check("mid_reset.dv_before", dv_cnt, 0);
    rst_n = 1'b0;
    #1;
    check("mid_reset.dv", digit_valid, 0);
    check_digits("mid_reset", 0, 0, 0);
    prev_pulse = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run(10'b0100000000, 15, 25, -1, -1, -2, 0);
    check("post_reset.dv_count", dv_cnt, 1);
    check("post_reset.latency", first_dv, LAT);
    check_digits("post_reset", 0, 0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
